// File: rtl/panel_bus_master.sv
// Takes over a halted 6502 bus and runs one timed read or write cycle on it.
// Build option PANEL_BUS_READBACK_EN: every write is followed by a verify read of the same address.
module panel_bus_master #(
  parameter int SETUP_CYC  = 3,
  parameter int STROBE_CYC = 12,
  parameter int TURN_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        cpu_halted,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] bus_A,
  input  logic [7:0]  bus_D_in,
  output logic [7:0]  bus_D_out,
  output logic        bus_D_oe,
  output logic        bus_RW,
  output logic        bus_PHI2,
  output logic        drive_busN
);

  // state         | meaning
  // IDLE          | bus owned by CPU, waiting for req
  // WAIT_GRANT    | request latched, waiting for cpu_halted
  // ACQUIRE       | bus taken, turnaround before driving
  // SETUP         | address/RW (and write data) valid, PHI2 low
  // STROBE        | PHI2 high, read data sampled on last cycle
  // HOLD          | PHI2 low, bus values held for one cycle
  // VERIFY_SETUP  | readback read, address valid, RW=1
  // VERIFY_STROBE | readback read, PHI2 high
  // VERIFY_HOLD   | readback read, hold
  // RELEASE       | drivers off, turnaround before handing bus back
  typedef enum logic [3:0] {
    IDLE,
    WAIT_GRANT,
    ACQUIRE,
    SETUP,
    STROBE,
    HOLD,
    VERIFY_SETUP,
    VERIFY_STROBE,
    VERIFY_HOLD,
    RELEASE
  } state_t;

  localparam int MAX_ST  = (SETUP_CYC > TURN_CYC) ? SETUP_CYC : TURN_CYC;
  localparam int MAX_CYC = (STROBE_CYC > MAX_ST) ? STROBE_CYC : MAX_ST;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
`ifdef PANEL_BUS_READBACK_EN
  logic          err_q, err_d;
`endif

  logic          cnt_tc;
  logic [CW-1:0] cnt_dec;
  logic          in_cycle;
  logic          own_bus;
  logic          wr_phase;

  assign cnt_tc  = (cnt_q == '0);
  assign cnt_dec = cnt_q - CW'(1);

  // States during which losing the grant aborts the cycle.
  assign in_cycle = (state_q == ACQUIRE) || (state_q == SETUP) || (state_q == STROBE) ||
                    (state_q == HOLD) || (state_q == VERIFY_SETUP) ||
                    (state_q == VERIFY_STROBE) || (state_q == VERIFY_HOLD);
  assign own_bus  = in_cycle || (state_q == RELEASE);
  assign wr_phase = we_q && ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = abort_q;
`ifdef PANEL_BUS_READBACK_EN
    err_d   = err_q;
`endif

    if (in_cycle && !cpu_halted) begin
      state_d = RELEASE;
      cnt_d   = TURN_LD;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // done_q blocks a req arriving in the completion cycle.
          if (req && !done_q) begin
            we_d    = we;
            addr_d  = addr;
            wdata_d = wdata;
            busy_d  = 1'b1;
            abort_d = 1'b0;
`ifdef PANEL_BUS_READBACK_EN
            err_d   = 1'b0;
`endif
            state_d = WAIT_GRANT;
          end
        end
        WAIT_GRANT: begin
          if (cpu_halted) begin
            state_d = ACQUIRE;
            cnt_d   = TURN_LD;
          end
        end
        ACQUIRE: begin
          if (cnt_tc) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        SETUP: begin
          if (cnt_tc) begin
            state_d = STROBE;
            cnt_d   = STROBE_LD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        STROBE: begin
          if (cnt_tc) begin
            if (!we_q) begin
              rdata_d = bus_D_in;
            end
            state_d = HOLD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        HOLD: begin
          state_d = RELEASE;
          cnt_d   = TURN_LD;
`ifdef PANEL_BUS_READBACK_EN
          if (we_q) begin
            state_d = VERIFY_SETUP;
            cnt_d   = SETUP_LD;
          end
`endif
        end
`ifdef PANEL_BUS_READBACK_EN
        VERIFY_SETUP: begin
          if (cnt_tc) begin
            state_d = VERIFY_STROBE;
            cnt_d   = STROBE_LD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        VERIFY_STROBE: begin
          if (cnt_tc) begin
            rdata_d = bus_D_in;
            err_d   = (bus_D_in != wdata_q);
            state_d = VERIFY_HOLD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        VERIFY_HOLD: begin
          state_d = RELEASE;
          cnt_d   = TURN_LD;
        end
`endif
        RELEASE: begin
          if (cnt_tc) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

`ifdef PANEL_BUS_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Bus pins decode straight from state so reset releases the bus without a clock edge.
  assign drive_busN = ~own_bus;
  assign bus_PHI2   = (state_q == STROBE) || (state_q == VERIFY_STROBE);
  assign bus_D_oe   = wr_phase;
  assign bus_RW     = ~wr_phase;
  assign bus_D_out  = wdata_q;
  assign bus_A      = addr_q;

  assign busy  = busy_q;
  assign done  = done_q;
  assign abort = abort_q;
  assign rdata = rdata_q;

endmodule
